// File: rtl/trng_pkg.sv
// trng_pkg: shared state encoding and word width for the TRNG sampling path
package trng_pkg;
  localparam int TRNG_W = 16;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SEED   = 3'd1,
    WARMUP = 3'd2,
    RUN    = 3'd3,
    FAIL   = 3'd4
  } state_t;
endpackage

// File: rtl/trng_fifo.sv
// trng_fifo: registered show-ahead FIFO with flush, full/empty and occupancy count
module trng_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr, rd;
  logic do_push, do_pop;
  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr    <= '0;
      rd    <= '0;
      count <= '0;
    end else if (flush) begin
      wr    <= '0;
      rd    <= '0;
      count <= '0;
    end else begin
      wr    <= do_push ? wr + 1'b1 : wr;
      rd    <= do_pop ? rd + 1'b1 : rd;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr] <= din;
  end
endmodule

// File: rtl/trng_sample_ctrl.sv
// trng_sample_ctrl: seeds the TRNG core, warms it up, decimates, health-tests and buffers output words
module trng_sample_ctrl
  import trng_pkg::*;
#(
  parameter int WARMUP_CYCLES = 64,
  parameter int DECIM         = 4,
  parameter int REP_LIMIT     = 4,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic [TRNG_W-1:0] seed_i,
  input  logic              clr_fail_i,
  input  logic [TRNG_W-1:0] raw_i,
  output logic [TRNG_W-1:0] core_seed_o,
  output logic              core_load_o,
  output logic [TRNG_W-1:0] out_data_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              health_fail_o,
  output logic              overrun_o,
  output logic [2:0]        state_o
);
  localparam int WW = WARMUP_CYCLES > 1 ? $clog2(WARMUP_CYCLES) : 1;
  localparam int DW = DECIM > 1 ? $clog2(DECIM) : 1;
  localparam int RW = $clog2(REP_LIMIT + 1);
  state_t state, state_n;
  logic [WW-1:0] wcnt;
  logic [DW-1:0] dcnt;
  logic [RW-1:0] rep, rep_n;
  logic [TRNG_W-1:0] last;
  logic have_last, sample, hit, push, pop, flush, full, empty;
  logic [$clog2(FIFO_DEPTH):0] count;
  assign sample = state == RUN && dcnt == DW'(DECIM - 1);
  assign rep_n  = (have_last && raw_i == last) ? (rep == RW'(REP_LIMIT) ? rep : rep + 1'b1) : RW'(1);
  assign hit    = sample && rep_n == RW'(REP_LIMIT);
  assign push   = sample && !hit && en_i;
  assign pop    = out_ready_i && !empty;
  assign flush  = state_n == IDLE || state_n == FAIL;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = en_i ? SEED : IDLE;
      SEED:    state_n = en_i ? WARMUP : IDLE;
      WARMUP:  state_n = !en_i ? IDLE : (wcnt == WW'(WARMUP_CYCLES - 1)) ? RUN : WARMUP;
      RUN:     state_n = !en_i ? IDLE : hit ? FAIL : RUN;
      FAIL:    state_n = clr_fail_i ? IDLE : FAIL;
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    core_load_o   = state == SEED;
    core_seed_o   = state == SEED ? seed_i : '0;
    health_fail_o = state == FAIL;
    state_o       = state;
    out_valid_o   = |count;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt      <= '0;
      dcnt      <= '0;
      rep       <= '0;
      last      <= '0;
      have_last <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      wcnt      <= state == WARMUP ? wcnt + 1'b1 : '0;
      dcnt      <= state != RUN ? '0 : dcnt == DW'(DECIM - 1) ? '0 : dcnt + 1'b1;
      rep       <= state != RUN ? '0 : sample ? rep_n : rep;
      last      <= state != RUN ? '0 : sample ? raw_i : last;
      have_last <= state != RUN ? 1'b0 : have_last || sample;
      overrun_o <= state_n == SEED ? 1'b0 : (push && full && !pop) ? 1'b1 : overrun_o;
    end
  end
  trng_fifo #(.W(TRNG_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (raw_i),
    .dout  (out_data_o),
    .full  (full),
    .empty (empty),
    .count (count)
  );
endmodule

// File: tb/tb_trng_sample_ctrl.sv
// tb_trng_sample_ctrl: directed bring-up, decimation, backpressure, health, full pop/push and abort checks
module tb_trng_sample_ctrl;
  logic clk = 1'b0, rst = 1'b1, en_i = 1'b0, clr_fail_i = 1'b0, out_ready_i = 1'b0;
  logic [15:0] seed_i = '0, raw_i = '0;
  logic [15:0] core_seed_o, out_data_o;
  logic core_load_o, out_valid_o, health_fail_o, overrun_o;
  logic [2:0] state_o;
  int n_tests = 0, n_fail = 0;
  trng_sample_ctrl #(.WARMUP_CYCLES(8), .DECIM(4), .REP_LIMIT(3), .FIFO_DEPTH(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .en_i          (en_i),
    .seed_i        (seed_i),
    .clr_fail_i    (clr_fail_i),
    .raw_i         (raw_i),
    .core_seed_o   (core_seed_o),
    .core_load_o   (core_load_o),
    .out_data_o    (out_data_o),
    .out_valid_o   (out_valid_o),
    .out_ready_i   (out_ready_i),
    .health_fail_o (health_fail_o),
    .overrun_o     (overrun_o),
    .state_o       (state_o)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic seed_to_run(input logic [15:0] s);
    en_i = 1'b1;
    seed_i = s;
    tick();
    check("seed_state", 32'(state_o), 1);
    check("seed_load", 32'(core_load_o), 1);
    check("seed_value", 32'(core_seed_o), 32'(s));
    tick();
    check("warm_load", 32'(core_load_o), 0);
    check("warm_seed", 32'(core_seed_o), 0);
    repeat (7) tick();
    check("warm_end", 32'(state_o), 2);
    tick();
    check("run_entry", 32'(state_o), 3);
  endtask
  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"}, 32'(state_o), 0);
    check({tag, "_load"}, 32'(core_load_o), 0);
    check({tag, "_seed"}, 32'(core_seed_o), 0);
    check({tag, "_data"}, 32'(out_data_o), 0);
    check({tag, "_valid"}, 32'(out_valid_o), 0);
    check({tag, "_hfail"}, 32'(health_fail_o), 0);
    check({tag, "_overrun"}, 32'(overrun_o), 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    seed_i = 16'h5A5A;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();
    seed_to_run(16'hACE1);
    raw_i = 16'h1234;
    repeat (3) tick();
    check("first_pre", 32'(out_valid_o), 0);
    tick();
    check("first_valid", 32'(out_valid_o), 1);
    check("first_data", 32'(out_data_o), 'h1234);
    for (int c = 4; c < 44; c++) begin
      if (c % 4 == 0 && c >= 8 && c <= 16) begin
        check("decim_valid", 32'(out_valid_o), 1);
        check("decim_data", 32'(out_data_o), 32'('hA000 + c - 1));
      end
      if (c == 5 || c == 9 || c == 13) check("decim_gap", 32'(out_valid_o), 0);
      if (c == 24 || c == 32) check("stall_data", 32'(out_data_o), 'hA013);
      if (c == 34) check("overrun_pre", 32'(overrun_o), 0);
      if (c == 36) check("overrun_set", 32'(overrun_o), 1);
      if (c >= 40) check("drain_data", 32'(out_data_o), 32'('hA013 + 4 * (c - 40)));
      raw_i = 16'(32'hA000 + c);
      out_ready_i = (c <= 16 || c >= 40);
      tick();
    end
    raw_i = 16'h5555;
    out_ready_i = 1'b0;
    repeat (11) tick();
    check("health_pre_state", 32'(state_o), 3);
    check("health_pre_valid", 32'(out_valid_o), 1);
    tick();
    check("fail_state", 32'(state_o), 4);
    check("fail_flag", 32'(health_fail_o), 1);
    check("fail_valid", 32'(out_valid_o), 0);
    check("fail_overrun_sticky", 32'(overrun_o), 1);
    en_i = 1'b0;
    tick();
    check("fail_en_low", 32'(state_o), 4);
    en_i = 1'b1;
    tick();
    check("fail_en_high", 32'(state_o), 4);
    clr_fail_i = 1'b1;
    tick();
    clr_fail_i = 1'b0;
    check("clr_state", 32'(state_o), 0);
    check("clr_flag", 32'(health_fail_o), 0);
    seed_to_run(16'h0F0F);
    check("reseed_overrun", 32'(overrun_o), 0);
    for (int c = 0; c < 28; c++) begin
      if (c == 16) begin
        check("full_valid", 32'(out_valid_o), 1);
        check("full_head", 32'(out_data_o), 'hB003);
        check("full_overrun", 32'(overrun_o), 0);
      end
      if (c == 20) begin
        check("pushpop_overrun", 32'(overrun_o), 0);
        check("pushpop_head", 32'(out_data_o), 'hB007);
      end
      if (c == 24) begin
        check("still_full_overrun", 32'(overrun_o), 1);
        check("still_full_head", 32'(out_data_o), 'hB007);
      end
      if (c == 25) check("pp_drain1", 32'(out_data_o), 'hB00B);
      if (c == 26) check("pp_drain2", 32'(out_data_o), 'hB00F);
      if (c == 27) check("pp_drain3", 32'(out_data_o), 'hB013);
      raw_i = 16'(32'hB000 + c);
      out_ready_i = (c == 19 || c >= 24);
      tick();
    end
    en_i = 1'b0;
    tick();
    check("abort_run_state", 32'(state_o), 0);
    check("abort_run_valid", 32'(out_valid_o), 0);
    en_i = 1'b1;
    repeat (4) tick();
    check("mid_warm_state", 32'(state_o), 2);
    en_i = 1'b0;
    tick();
    check("abort_warm_state", 32'(state_o), 0);
    seed_to_run(16'h1111);
    out_ready_i = 1'b0;
    for (int c = 0; c < 9; c++) begin
      raw_i = 16'(32'hC000 + c);
      tick();
    end
    check("pre_rst_valid", 32'(out_valid_o), 1);
    check("pre_rst_data", 32'(out_data_o), 'hC003);
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    en_i = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_state", 32'(state_o), 0);
    check("post_rst_valid", 32'(out_valid_o), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
